nios_setup_v2_debug_vjtag_master: RTL

Virtual-JTAG initiator for the Nios II debug slave: accepts a debug command (2-bit IR code plus 38-bit DR payload) on a valid/ready interface and replays the virtual-JTAG state sequence UIR → CDR → SDR×38 → UDR → RTI on the `vji_*` signal set, returning the captured IR and TDO bits as a response. It drives the debug slave's TAP-side ports directly from the system clock. It replaces host-side JTAG for on-chip self-debug and for simulation benches of the debug slave.

---
 rtl/nios_setup_v2_debug_pkg.sv | 23 ++
 rtl/nios_setup_v2_debug_vjtag_tck_gen.sv | 37 +++
 rtl/nios_setup_v2_debug_vjtag_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nios_setup_v2_debug_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG initiator.
// Holds the replay state enum, default scan widths and the debug IR codes.
package nios_setup_v2_debug_pkg;

    localparam int IR_W_DEF = 2;
    localparam int DR_W_DEF = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UIR   = 3'd1,
        ST_CDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_UDR   = 3'd4,
        ST_RTI   = 3'd5,
        ST_RESP  = 3'd6
    } vjtag_state_t;

endpackage

// File: rtl/nios_setup_v2_debug_vjtag_tck_gen.sv
// TCK generator: each period is TCK_DIV clk low then TCK_DIV clk high, held low when disabled.
// tck_rise/tck_fall flag the clk cycle whose closing edge raises/lowers vji_tck.
module nios_setup_v2_debug_vjtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic vji_tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam logic [8:0] HALF_END   = 9'(TCK_DIV - 1);
    localparam logic [8:0] PERIOD_END = 9'(2 * TCK_DIV - 1);

    logic [8:0] cnt;

    assign tck_rise = en && (cnt == HALF_END);
    assign tck_fall = en && (cnt == PERIOD_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            vji_tck <= 1'b0;
        end else if (!en || tck_fall) begin
            cnt     <= '0;
            vji_tck <= 1'b0;
        end else begin
            cnt <= cnt + 9'd1;
            if (tck_rise) begin
                vji_tck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_setup_v2_debug_vjtag_master.sv
// Virtual-JTAG initiator replaying UIR/CDR/SDR/UDR/RTI for one debug command per transaction.
// Optional NIOS_DEBUG_VJTAG_IR_CACHE_EN skips UIR when the requested IR is already loaded.
module nios_setup_v2_debug_vjtag_master
    import nios_setup_v2_debug_pkg::*;
#(
    parameter int IR_W    = IR_W_DEF,
    parameter int DR_W    = DR_W_DEF,
    parameter int TCK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    input  logic            cmd_ir_only,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IR_W-1:0] rsp_ir,
    output logic [DR_W-1:0] rsp_dr,
    output logic            vji_tck,
    output logic            vji_tdi,
    input  logic            vji_tdo,
    output logic [IR_W-1:0] vji_ir_in,
    input  logic [IR_W-1:0] vji_ir_out,
    output logic            vji_uir,
    output logic            vji_cdr,
    output logic            vji_sdr,
    output logic            vji_udr,
    output logic            vji_rti,
    output vjtag_state_t    dbg_state
);

    // Handshakes: a beat transfers on the clk edge where valid && ready; valid never
    // drops and payload never changes until that edge.

    localparam int BIT_W = $clog2(DR_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DR_W - 1);

    vjtag_state_t    state;
    logic [DR_W-1:0] dr_q;
    logic [DR_W-1:0] sr;
    logic [BIT_W-1:0] bit_cnt;
    logic            ir_only_q;
    logic            tck_en;
    logic            tck_rise;
    logic            tck_fall;
    logic            ir_hit;

    assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

    nios_setup_v2_debug_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (tck_en),
        .vji_tck  (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

`ifdef NIOS_DEBUG_VJTAG_IR_CACHE_EN
    logic            cache_valid;
    logic [IR_W-1:0] cache_ir;
    logic [IR_W-1:0] cache_ir_out;

    assign ir_hit = cache_valid && (cmd_ir == cache_ir) && !cmd_ir_only;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid  <= 1'b0;
            cache_ir     <= '0;
            cache_ir_out <= '0;
        end else if (state == ST_UIR && tck_rise) begin
            cache_valid  <= 1'b1;
            cache_ir     <= vji_ir_in;
            cache_ir_out <= vji_ir_out;
        end
    end
`else
    assign ir_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ir    <= '0;
            rsp_dr    <= '0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            dr_q      <= '0;
            sr        <= '0;
            bit_cnt   <= '0;
            ir_only_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        vji_ir_in <= cmd_ir;
                        dr_q      <= cmd_dr;
                        ir_only_q <= cmd_ir_only;
`ifdef NIOS_DEBUG_VJTAG_IR_CACHE_EN
                        if (ir_hit) begin
                            state  <= ST_CDR;
                            rsp_ir <= cache_ir_out;
                        end else begin
                            state <= ST_UIR;
                        end
`else
                        state <= ir_hit ? ST_CDR : ST_UIR;
`endif
                    end
                end
                ST_UIR: begin
                    if (tck_rise) rsp_ir <= vji_ir_out;
                    if (tck_fall) state <= ir_only_q ? ST_RTI : ST_CDR;
                end
                ST_CDR: begin
                    if (tck_fall) begin
                        state   <= ST_SHIFT;
                        sr      <= dr_q;
                        vji_tdi <= dr_q[0];
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    // Capture on the rise, present the next bit on the following fall.
                    if (tck_rise) sr <= {vji_tdo, sr[DR_W-1:1]};
                    if (tck_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            state   <= ST_UDR;
                            vji_tdi <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            vji_tdi <= sr[0];
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_fall) state <= ST_RTI;
                end
                ST_RTI: begin
                    if (tck_fall) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_dr    <= ir_only_q ? '0 : sr;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign vji_uir   = (state == ST_UIR);
    assign vji_cdr   = (state == ST_CDR);
    assign vji_sdr   = (state == ST_SHIFT);
    assign vji_udr   = (state == ST_UDR);
    assign vji_rti   = (state == ST_RTI);
    assign dbg_state = state;

endmodule
